column3_gen: RTL and testbench

COLUMN3_GEN -- requirements
Module: column3_gen

---
 rtl/sgbm_pkg.sv | 9 +
 rtl/column3_gen_line_buffer.sv | 20 ++
 rtl/column3_gen.sv | 83 ++++++++
 tb/tb_column3_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sgbm_pkg.sv
// sgbm_pkg: shared pixel and image geometry defaults for the SGBM pipeline.
package sgbm_pkg;
    localparam int PixWidth     = 8;
    localparam int ImgWidthDef  = 640;
    localparam int ImgHeightDef = 480;
    function automatic int cnt_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/column3_gen_line_buffer.sv
// line_buffer: one image row of pixels, combinational read, write on enable.
module line_buffer
    import sgbm_pkg::*;
#(
    parameter int Width     = PixWidth,
    parameter int Depth     = ImgWidthDef,
    parameter int AddrWidth = cnt_bits(Depth)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [Width-1:0]     wdata,
    output logic [Width-1:0]     rdata
);
    // contents are never reset: the top-border rule hides stale rows
    logic [Width-1:0] mem [Depth];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/column3_gen.sv
// column3_gen: turns a raster pixel stream into vertical 3-pixel columns
// (rows y-2, y-1, y) with top-border replication and valid/ready handshakes.
module column3_gen
    import sgbm_pkg::*;
#(
    parameter int Width     = PixWidth,
    parameter int ImgWidth  = ImgWidthDef,
    parameter int ImgHeight = ImgHeightDef,
    parameter int CW        = cnt_bits(ImgWidth),
    parameter int RW        = cnt_bits(ImgHeight)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [Width-1:0] i_pixel,
    input  logic             i_sof,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Width-1:0] o_d0,
    output logic [Width-1:0] o_d1,
    output logic [Width-1:0] o_d2,
    output logic [CW-1:0]    o_col,
    output logic [RW-1:0]    o_row,
    output logic             o_sof,
    output logic             o_eol
);
    logic [CW-1:0]    col_cnt, cur_col, nxt_col;
    logic [RW-1:0]    row_cnt, cur_row, nxt_row;
    logic             accept, last_col, last_row;
    logic [Width-1:0] lb0_q, lb1_q, d0_n, d1_n;

    assign o_ready = i_ready || !o_valid;
    assign accept  = i_valid && o_ready;

    // i_sof forces the current pixel to (0,0) whatever the counters say
    always_comb begin
        cur_col  = i_sof ? '0 : col_cnt;
        cur_row  = i_sof ? '0 : row_cnt;
        last_col = cur_col == CW'(ImgWidth - 1);
        last_row = cur_row == RW'(ImgHeight - 1);
        nxt_col  = last_col ? '0 : cur_col + 1'b1;
        nxt_row  = !last_col ? cur_row : last_row ? '0 : cur_row + 1'b1;
        d1_n     = cur_row == '0 ? i_pixel : lb0_q;
        d0_n     = cur_row == '0 ? i_pixel : cur_row == RW'(1) ? lb0_q : lb1_q;
    end

    line_buffer #(.Width(Width), .Depth(ImgWidth), .AddrWidth(CW)) u_lb0 (
        .clk(clk), .we(accept), .addr(cur_col), .wdata(i_pixel), .rdata(lb0_q)
    );

    line_buffer #(.Width(Width), .Depth(ImgWidth), .AddrWidth(CW)) u_lb1 (
        .clk(clk), .we(accept), .addr(cur_col), .wdata(lb0_q), .rdata(lb1_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            o_valid <= 1'b0;
            o_d0    <= '0;
            o_d1    <= '0;
            o_d2    <= '0;
            o_col   <= '0;
            o_row   <= '0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
        end else begin
            if (accept) begin
                col_cnt <= nxt_col;
                row_cnt <= nxt_row;
                o_d0    <= d0_n;
                o_d1    <= d1_n;
                o_d2    <= i_pixel;
                o_col   <= cur_col;
                o_row   <= cur_row;
                o_sof   <= cur_row == '0 && cur_col == '0;
                o_eol   <= last_col;
            end
            o_valid <= accept || (o_valid && !i_ready);
        end
    end
endmodule

// File: tb/tb_column3_gen.sv
// tb_column3_gen: directed stimulus with a queue scoreboard on a 4x3 image.
module tb_column3_gen;
    localparam int W  = 8;
    localparam int IW = 4;
    localparam int IH = 3;

    typedef struct {
        int d0, d1, d2, col, row;
        bit sof, eol;
    } exp_t;

    logic         clk = 0, rst_n = 0;
    logic         i_valid = 0, i_sof = 0, i_ready = 1;
    logic [W-1:0] i_pixel = '0;
    logic         o_ready, o_valid, o_sof, o_eol;
    logic [W-1:0] o_d0, o_d1, o_d2;
    logic [1:0]   o_col, o_row;

    exp_t q[$];
    int   checks = 0, errors = 0;

    column3_gen #(.Width(W), .ImgWidth(IW), .ImgHeight(IH)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_pixel(i_pixel), .i_sof(i_sof), .o_valid(o_valid), .i_ready(i_ready),
        .o_d0(o_d0), .o_d1(o_d1), .o_d2(o_d2), .o_col(o_col), .o_row(o_row),
        .o_sof(o_sof), .o_eol(o_eol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: a column is consumed whenever o_valid && i_ready before the edge
    initial forever begin
        @(negedge clk);
        if (rst_n && o_valid && i_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_column: got d=(%0d,%0d,%0d) at (%0d,%0d) with nothing expected",
                         o_d0, o_d1, o_d2, o_row, o_col);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.d0 != int'(o_d0) || e.d1 != int'(o_d1) || e.d2 != int'(o_d2) ||
                    e.col != int'(o_col) || e.row != int'(o_row) || e.sof != o_sof || e.eol != o_eol) begin
                    errors++;
                    $display("FAIL column: got d=(%0d,%0d,%0d) row=%0d col=%0d sof=%0b eol=%0b, expected d=(%0d,%0d,%0d) row=%0d col=%0d sof=%0b eol=%0b",
                             o_d0, o_d1, o_d2, o_row, o_col, o_sof, o_eol,
                             e.d0, e.d1, e.d2, e.row, e.col, e.sof, e.eol);
                end
            end
        end
    end

    task automatic send(input int pix, input logic sof, input int er, input int ec,
                        input int e0, input int e1, input int e2);
        bit done = 0;
        i_valid = 1;
        i_pixel = W'(pix);
        i_sof   = sof;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (o_ready) begin
                q.push_back('{d0: e0, d1: e1, d2: e2, col: ec, row: er,
                              sof: (er == 0 && ec == 0), eol: (ec == IW - 1)});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        i_sof = 0;
    endtask

    // hand rule for a clean frame of pixel 10*r+c
    task automatic std(input int r, input int c, input logic sof);
        int p;
        p = 10 * r + c;
        send(p, sof, r, c, r == 0 ? p : r == 1 ? p - 10 : p - 20, r == 0 ? p : p - 10, p);
    endtask

    task automatic frame(input bit sof_first, input bit stall);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                std(r, c, sof_first && r == 0 && c == 0);
                if (stall && r == 2 && c == 1) begin
                    i_ready = 0;
                    i_pixel = 8'd22;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("stall_o_ready", o_ready, 0);
                        chk("stall_o_valid", o_valid, 1);
                        chk("stall_d0", o_d0, 1);
                        chk("stall_d1", o_d1, 11);
                        chk("stall_d2", o_d2, 21);
                        chk("stall_pos", {o_row, o_col}, {2'd2, 2'd1});
                        @(posedge clk);
                        #1;
                    end
                    i_ready = 1;
                end
            end
    endtask

    task automatic drain();
        i_valid = 0;
        for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_o_valid"}, o_valid, 0);
        chk({tag, "_o_ready"}, o_ready, 1);
        chk({tag, "_data"}, {o_d0, o_d1, o_d2}, 0);
        chk({tag, "_pos_flags"}, {o_row, o_col, o_sof, o_eol}, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1;
        @(posedge clk);
        #1;
        frame(1, 0);
        frame(0, 1);
        drain();
        // mid-frame reset while the (1,1) column is pending
        for (int c = 0; c < IW; c++) std(0, c, 0);
        std(1, 0, 0);
        std(1, 1, 0);
        i_valid = 0;
        rst_n = 0;
        #1;
        reset_checks("async_reset");
        void'(q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        reset_checks("held_reset");
        rst_n = 1;
        frame(0, 0);
        drain();
        // stray i_sof mid-frame restarts at (0,0)
        for (int c = 0; c < IW; c++) std(0, c, 0);
        std(1, 0, 0);
        std(1, 1, 0);
        send(12, 1, 0, 0, 12, 12, 12);
        send(13, 0, 0, 1, 13, 13, 13);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
